// File: rtl/alu_accumulator.sv
// Accumulator ALU stage: folds the B bus into AC under a 4-bit opcode.
// Single-cycle arithmetic/shift ops plus a 24-iteration shift-add multiply.
module alu_accumulator #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] B_bus,
    input  logic [3:0]       alu_op,
    input  logic             start,
    output logic [WIDTH-1:0] AC,
    output logic             Z,
    output logic             C,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_CLR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ac_q, ac_d;
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Extended results: the top bit is the carry (ADD/INC) or borrow (SUB).
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH:0]     inc_ext;
    logic [WIDTH-1:0]   mul_acc;

    assign add_ext = {1'b0, ac_q} + {1'b0, B_bus};
    assign sub_ext = {1'b0, ac_q} - {1'b0, B_bus};
    assign inc_ext = {1'b0, ac_q} + (WIDTH + 1)'(1);
    assign mul_acc = mplier_q[0] ? (product_q + mcand_q) : product_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ac_q      <= '0;
            z_q       <= 1'b1;
            c_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ac_q      <= ac_d;
            z_q       <= z_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        c_d       = c_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = (alu_op != OP_MUL);
                    case (alu_op)
                        OP_NOP:  ;
                        OP_LOAD: ac_d = B_bus;
                        OP_ADD:  {c_d, ac_d} = add_ext;
                        OP_SUB:  {c_d, ac_d} = sub_ext;
                        OP_INC:  {c_d, ac_d} = inc_ext;
                        OP_SHR: begin
                            ac_d = {1'b0, ac_q[WIDTH-1:1]};
                            c_d  = ac_q[0];
                        end
                        OP_SHL: begin
                            ac_d = {ac_q[WIDTH-2:0], 1'b0};
                            c_d  = ac_q[WIDTH-1];
                        end
                        OP_CLR: begin
                            ac_d = '0;
                            c_d  = 1'b0;
                        end
                        OP_MUL: begin
                            mcand_d   = ac_q;
                            mplier_d  = B_bus;
                            product_d = '0;
                            count_d   = '0;
                            busy_d    = 1'b1;
                            state_d   = MUL;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                // Fixed-length iteration; start requests are ignored here.
                product_d = mul_acc;
                mcand_d   = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d  = {1'b0, mplier_q[WIDTH-1:1]};
                count_d   = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    ac_d    = mul_acc;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        z_d = (ac_d == '0);
    end

    assign AC   = ac_q;
    assign Z    = z_q;
    assign C    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/alu_accumulator.md
Name: alu_accumulator

Overview:
- Datapath stage directly downstream of the B-bus source-select stage.
- Consumes the 24-bit B bus and combines it with a 24-bit accumulator (AC) under a 4-bit ALU opcode from the control unit.
- Single-cycle ops: load, add, subtract, increment, shifts, clear.
- Multi-cycle op: 24-iteration shift-add multiply, used by the downsampling kernel for weight scaling.
- AC, zero flag and carry flag are registered and feed the C-bus and branch logic.

Parameters:
- WIDTH, 24, data width of B bus and AC.
- CNT_W, 5, width of the multiply iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- B_bus  input  24  operand from the B-bus select stage.
- alu_op  input  4  opcode, sampled only on a start edge.
- start  input  1  single-cycle request pulse from the control unit.
- AC  output  24  accumulator register.
- Z  output  1  registered zero flag, (AC == 0).
- C  output  1  registered carry/borrow flag.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): AC=0, Z=1, C=0, busy=0, done=0; FSM goes to IDLE; internal multiplicand, multiplier, product and count are cleared.
- FSM states: IDLE and MUL.
- Opcodes. Each is sampled at a rising edge where state=IDLE and start=1.
  - 0000 NOP: AC unchanged.
  - 0001 LOAD: AC<=B_bus.
  - 0010 ADD: {C,AC}<=AC+B_bus, 25-bit sum.
  - 0011 SUB: AC<=AC-B_bus; C<=1 iff B_bus>AC, unsigned borrow.
  - 0100 INC: {C,AC}<=AC+1.
  - 0101 SHR: AC<=AC>>1, logical; C<=old AC[0].
  - 0110 SHL: AC<=AC<<1; C<=old AC[23].
  - 0111 CLR: AC<=0, C<=0.
  - 1000 MUL: multi-cycle, see below.
  - 1001–1111: treated as NOP.
- C is unchanged by NOP, LOAD and MUL.
- Single-cycle ops: AC/C are written at the sampling edge; done=1 for exactly the following cycle; busy stays 0.
- Z is registered and updated on every edge that writes AC. It reflects the new AC value in the same cycle that done is high.
- MUL:
  - At the start edge, capture mcand<=AC, mplier<=B_bus, product<=0, count<=0; state<=MUL; busy<=1.
  - Each MUL edge:
    - if mplier[0]=1, product<=product+mcand, truncated to 24 bits;
    - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - On the edge where count==23, AC<=final product (including that iteration's add), Z is updated, busy<=0, done<=1, state<=IDLE.
  - Latency: start edge at cycle 0, AC valid and done high in cycle 25. busy is high in cycles 1..24.
  - Result is (AC*B_bus) mod 2^24, unsigned. There is no early termination.
- start while busy=1 is ignored: no queueing, no error, and alu_op is not sampled.
- start at the edge where the multiply finishes is also ignored, since state is still MUL at that edge.
- done is never asserted without a preceding accepted start. Back-to-back single-cycle starts on consecutive cycles are each accepted; done stays high continuously in that case.
- Reset asserted mid-MUL aborts the multiply immediately: all outputs return to reset values and no done pulse is produced.
- B_bus and alu_op may change freely while busy; a multiply uses only the operands captured at its start edge.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> AC=0x000000, Z=1, C=0, busy=0, done=0.
- LOAD 0x000010, then ADD with B_bus=0xFFFFF0 -> after ADD: AC=0x000000, Z=1, C=1, done high for one cycle per op.
- LOAD 0x000005, SUB with B_bus=0x000007 -> AC=0xFFFFFE, C=1, Z=0. SHR -> AC=0x7FFFFF, C=0.
- LOAD 0x000003, MUL with B_bus=0x000005 -> busy high 24 cycles, done in cycle 25, AC=0x00000F.
- LOAD 0x001000, MUL with B_bus=0x001000 -> AC=0x000000 (truncated), Z=1. Pulses of start with alu_op=LOAD at cycles 5 and 24 are ignored: AC unaffected, done only once.
- LOAD 0x0000FF, MUL with B_bus=0x000002, assert reset at cycle 10 -> AC=0, busy=0, no done. A following LOAD 0x000001 works normally.
